regfile_mp: RTL and testbench

Parametrised multi-port register file for the multi-cycle MIPS datapath. It generalises the architectural register file in data width, register count, read-port count and write-port count. It adds an optional hardwired zero register, write-to-read bypass, and a per-register pending scoreboard for multi-cycle loads. After reset, a clear sequencer zeroes the array one entry per cycle, so the storage can map to RAM-style resources instead of a full parallel reset.

---
 rtl/regfile_pkg.sv | 7 +
 rtl/regfile_scoreboard.sv | 39 +++
 rtl/regfile_mp.sv | 70 +++++++
 tb/tb_regfile_mp.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and address-width helper for regfile_mp
package regfile_pkg;
  typedef enum logic {INIT, RUN} state_t;
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits with set-over-clear and per-read-port lookup
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int NUM_REGS = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1,
  localparam int AW = addr_w(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_WR-1:0]    wen,
  input  logic [NUM_WR*AW-1:0] wa,
  input  logic                 set_en,
  input  logic [AW-1:0]        set_addr,
  input  logic [NUM_RD*AW-1:0] ra,
  output logic [NUM_RD-1:0]    pend_out
);
  logic [NUM_REGS-1:0] pend, set, clr;
  logic [AW-1:0] a;
  // decode this cycle's write clears and reservation set
  always_comb begin
    clr = '0;
    set = '0;
    for (int p = 0; p < NUM_WR; p++) if (wen[p]) clr[wa[p*AW +: AW]] = 1'b1;
    if (set_en) set[set_addr] = 1'b1;
  end
  // a reservation belongs to a younger instruction, so it beats a same-cycle clear
  always_ff @(posedge clk) pend <= rst ? '0 : set | (pend & ~clr);
  // per-port lookup: a same-cycle write forwards its clear unless a reservation lands too
  always_comb begin
    pend_out = '0;
    a = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      a = ra[i*AW +: AW];
      pend_out[i] = (ZERO_REG != 0 && a == '0) ? 1'b0 : (BYPASS != 0 && clr[a]) ? set[a] : pend[a];
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with zero register, bypass, pending scoreboard and clear sequencer
module regfile_mp import regfile_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1,
  localparam int AW = addr_w(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*AW-1:0]     wa,
  input  logic [NUM_WR*DATA_W-1:0] wd,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr,
  output logic                     ready
);
  logic [DATA_W-1:0] mem [NUM_REGS];
  state_t state, state_nxt;
  logic [AW-1:0] idx, a;
  logic [NUM_WR-1:0] wen;
  logic [NUM_RD-1:0] pend_out;
  logic [DATA_W-1:0] v;
  logic run, rsv_ok;
  assign run = state == RUN;
  assign ready = run;
  assign rsv_ok = run && rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);
  // qualify write ports: only in RUN, and never to the hardwired zero register
  always_comb begin
    wen = '0;
    for (int p = 0; p < NUM_WR; p++) wen[p] = run && we[p] && !(ZERO_REG != 0 && wa[p*AW +: AW] == '0);
  end
  // clear sequencer leaves INIT once the last entry has been zeroed
  always_comb state_nxt = (state == INIT && idx == AW'(NUM_REGS - 1)) ? RUN : state;
  // state and clear-index registers
  always_ff @(posedge clk) begin
    state <= rst ? INIT : state_nxt;
    idx <= rst ? '0 : (state == INIT) ? idx + AW'(1) : idx;
  end
  // array: sequential clear in INIT, otherwise ports in ascending order so the highest one wins
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) mem[idx] <= '0;
      else for (int p = 0; p < NUM_WR; p++) if (wen[p]) mem[wa[p*AW +: AW]] <= wd[p*DATA_W +: DATA_W];
    end
  end
  // read mux with optional same-cycle forwarding; outputs held at 0 until the clear completes
  always_comb begin
    rd = '0;
    a = '0;
    v = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      a = ra[i*AW +: AW];
      v = mem[a];
      if (BYPASS != 0) for (int p = 0; p < NUM_WR; p++) if (wen[p] && wa[p*AW +: AW] == a) v = wd[p*DATA_W +: DATA_W];
      rd[i*DATA_W +: DATA_W] = (!run || (ZERO_REG != 0 && a == '0)) ? '0 : v;
    end
  end
  assign rd_pend = run ? pend_out : '0;
  regfile_scoreboard #(
    .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_sb (
    .clk(clk), .rst(rst), .wen(wen), .wa(wa), .set_en(rsv_ok), .set_addr(rsv_addr), .ra(ra), .pend_out(pend_out)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scoreboard bench for regfile_mp (32x32, 2 read, 2 write ports)
module tb_regfile_mp;
  logic clk = 0;
  logic rst;
  logic [9:0] ra;
  logic [63:0] rd;
  logic [1:0] rd_pend;
  logic [1:0] we;
  logic [9:0] wa;
  logic [63:0] wd;
  logic rsv_en;
  logic [4:0] rsv_addr;
  logic ready;
  int n_chk = 0;
  int n_fail = 0;
  string q_name[$];
  int q_kind[$];
  int q_port[$];
  logic [31:0] q_exp[$];

  regfile_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd), .rd_pend(rd_pend), .we(we), .wa(wa), .wd(wd),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .ready(ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // kind 0: rd[port], kind 1: rd_pend[port], kind 2: ready
  task automatic expect_val(input string name, input int kind, input int port, input logic [31:0] exp);
    q_name.push_back(name);
    q_kind.push_back(kind);
    q_port.push_back(port);
    q_exp.push_back(exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; wa = 0; wd = 0; rsv_en = 0; rsv_addr = 0;
  endtask

  always @(negedge clk) begin
    while (q_name.size() > 0) begin
      string n;
      int k, p;
      logic [31:0] e, got;
      n = q_name.pop_front();
      k = q_kind.pop_front();
      p = q_port.pop_front();
      e = q_exp.pop_front();
      got = (k == 0) ? rd[p*32 +: 32] : (k == 1) ? {31'b0, rd_pend[p]} : {31'b0, ready};
      n_chk++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", n, got, e);
      end
    end
  end

  task automatic clear_sequence(input string tag);
    for (int k = 0; k <= 32; k++) begin
      expect_val({tag, "_ready"}, 2, 0, (k == 32) ? 32'd1 : 32'd0);
      if (k == 5) begin
        we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'h0, 32'hFFFF_FFFF}; ra = {5'd20, 5'd3};
        rsv_en = 1; rsv_addr = 5'd20;
        expect_val({tag, "_init_bypass_rd"}, 0, 0, 32'h0);
        expect_val({tag, "_init_pend"}, 1, 1, 32'h0);
      end else idle();
      step();
    end
    idle();
    for (int r = 0; r < 32; r += 2) begin
      ra = {5'(r + 1), 5'(r)};
      expect_val({tag, "_zero_rd0"}, 0, 0, 32'h0);
      expect_val({tag, "_zero_rd1"}, 0, 1, 32'h0);
      expect_val({tag, "_zero_pend0"}, 1, 0, 32'h0);
      expect_val({tag, "_zero_pend1"}, 1, 1, 32'h0);
      step();
    end
  endtask

  initial begin
    idle();
    ra = 0;
    rst = 1;
    #1;
    step();
    step();
    expect_val("reset_ready", 2, 0, 32'h0);
    expect_val("reset_rd", 0, 0, 32'h0);
    expect_val("reset_pend", 1, 0, 32'h0);
    step();
    rst = 0;
    clear_sequence("init");

    we = 2'b11; wa = {5'd5, 5'd5}; wd = {32'h2222_2222, 32'h1111_1111}; ra = {5'd0, 5'd5};
    expect_val("collide_bypass", 0, 0, 32'h2222_2222);
    step();
    idle();
    expect_val("collide_next", 0, 0, 32'h2222_2222);
    step();

    we = 2'b01; wa = {5'd0, 5'd0}; wd = {32'h0, 32'hDEAD_BEEF}; rsv_en = 1; rsv_addr = 0; ra = {5'd0, 5'd0};
    expect_val("r0_bypass_rd", 0, 0, 32'h0);
    expect_val("r0_bypass_pend", 1, 1, 32'h0);
    step();
    idle();
    for (int c = 0; c < 2; c++) begin
      expect_val("r0_rd", 0, 0, 32'h0);
      expect_val("r0_pend", 1, 0, 32'h0);
      step();
    end

    rsv_en = 1; rsv_addr = 5'd7; ra = {5'd7, 5'd7};
    step();
    idle();
    for (int c = 0; c < 3; c++) begin
      expect_val("r7_pend_held", 1, 0, 32'h1);
      expect_val("r7_pend_port1", 1, 1, 32'h1);
      step();
    end
    we = 2'b10; wa = {5'd7, 5'd0}; wd = {32'h0000_ABCD, 32'h0};
    expect_val("r7_write_pend", 1, 0, 32'h0);
    expect_val("r7_write_rd", 0, 0, 32'h0000_ABCD);
    step();
    idle();
    expect_val("r7_after_pend", 1, 0, 32'h0);
    expect_val("r7_after_rd", 0, 1, 32'h0000_ABCD);
    step();

    we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'h0, 32'h0000_9999}; rsv_en = 1; rsv_addr = 5'd9; ra = {5'd9, 5'd9};
    expect_val("r9_same_rd", 0, 0, 32'h0000_9999);
    expect_val("r9_same_pend", 1, 1, 32'h1);
    step();
    idle();
    expect_val("r9_next_rd", 0, 0, 32'h0000_9999);
    expect_val("r9_next_pend", 1, 0, 32'h1);
    step();

    we = 2'b11; wa = {5'd2, 5'd1}; wd = {32'hA5A5_0002, 32'hA5A5_0001}; ra = {5'd2, 5'd1};
    step();
    idle();
    expect_val("fill_r1", 0, 0, 32'hA5A5_0001);
    expect_val("fill_r2", 0, 1, 32'hA5A5_0002);
    step();

    rst = 1;
    ra = {5'd7, 5'd9};
    step();
    rst = 0;
    expect_val("rerst_ready", 2, 0, 32'h0);
    expect_val("rerst_rd", 0, 0, 32'h0);
    expect_val("rerst_pend", 1, 0, 32'h0);
    clear_sequence("rerun");

    n_chk++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL final_ready: got %b expected 1", ready);
    end
    n_chk++;
    if (rd !== 64'h0) begin
      n_fail++;
      $display("FAIL final_rd: got %h expected 0", rd);
    end
    n_chk++;
    if (rd_pend !== 2'b00) begin
      n_fail++;
      $display("FAIL final_pend: got %b expected 00", rd_pend);
    end

    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
